// File: rtl/pipelined_controller.sv
// RV32 decode controller with a sequencing FSM for multi-cycle memory, ecall wait and branch flush.
// Optional mul/div wait state is enabled by defining CTRL_MULDIV_EN.
//
// state      | meaning
// RUN        | decode and issue the current instruction
// MEM_WAIT   | lw/sw occupying extra memory cycles
// ECALL_WAIT | ecall pending until EcallDone
// MD_WAIT    | mul/div occupying extra cycles (CTRL_MULDIV_EN only)
// FLUSH      | fetched instruction squashed after a taken branch
module pipelined_controller #(
  parameter int MEM_LAT      = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int MULDIV_LAT   = 4,
  parameter int ALUOP_W      = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        inst_i,
  input  logic               doBranch_i,
  input  logic               EcallDone_i,
  output logic               MemRead_o,
  output logic               MemtoReg_o,
  output logic               MemWrite_o,
  output logic               RegWrite_o,
  output logic               Ecall_o,
  output logic [1:0]         ALUSrc_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               Stall_o,
  output logic               Flush_o
);

  localparam int MAXL01 = (MEM_LAT > FLUSH_CYCLES) ? MEM_LAT : FLUSH_CYCLES;
  localparam int MAXL   = (MAXL01 > MULDIV_LAT) ? MAXL01 : MULDIV_LAT;
  localparam int CW     = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

  typedef enum logic [2:0] {
    RUN,
    MEM_WAIT,
    ECALL_WAIT,
`ifdef CTRL_MULDIV_EN
    MD_WAIT,
`endif
    FLUSH
  } state_e;

  typedef struct packed {
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  ctrl_t         dec, dec_q, cur;
  logic          is_mem, is_ecall, is_md;
  logic          stall, flush, ecall, commit;
  logic [6:0]    op;
  logic          unused_bits;

  assign op          = inst_i[6:0];
  assign unused_bits = ^inst_i[31:7];

  always_comb begin
    dec      = '0;
    is_mem   = (op == 7'b0000011) || (op == 7'b0100011);
    is_ecall = (op == 7'b1110011);
    is_md    = 1'b0;
    case (op)
      7'b0110011: begin dec.alu_op = ALUOP_W'(0); dec.reg_write = 1'b1; end
      7'b0010011: begin dec.alu_op = ALUOP_W'(1); dec.reg_write = 1'b1; dec.alu_src = 2'b10; end
      7'b0000011: begin
        dec.alu_op     = ALUOP_W'(2);
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 2'b10;
      end
      7'b0100011: begin dec.alu_op = ALUOP_W'(2); dec.mem_write = 1'b1; dec.alu_src = 2'b10; end
      7'b1100011: dec.alu_op = ALUOP_W'(3);
      7'b1101111: begin dec.alu_op = ALUOP_W'(4); dec.reg_write = 1'b1; dec.alu_src = 2'b01; end
      7'b1100111: begin dec.alu_op = ALUOP_W'(5); dec.reg_write = 1'b1; dec.alu_src = 2'b01; end
      7'b0110111: begin dec.alu_op = ALUOP_W'(6); dec.reg_write = 1'b1; dec.alu_src = 2'b10; end
      7'b0010111: begin dec.alu_op = ALUOP_W'(1); dec.reg_write = 1'b1; dec.alu_src = 2'b11; end
      default:    dec = '0;
    endcase
`ifdef CTRL_MULDIV_EN
    if (op == 7'b0110011 && inst_i[31:25] == 7'b0000001) begin
      is_md      = 1'b1;
      dec.alu_op = ALUOP_W'(7);
    end
`endif
  end

  // Wait states act on the class latched at issue, not on whatever fetch holds now.
  assign cur = (state_q == RUN || state_q == FLUSH) ? dec : dec_q;

  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    ecall = 1'b0;
    case (state_q)
      RUN: begin
        if (is_ecall) begin
          ecall = 1'b1;
          stall = !EcallDone_i;
        end else if (is_mem && MEM_LAT > 0) begin
          stall = 1'b1;
        end else if (is_md && MULDIV_LAT > 0) begin
          stall = 1'b1;
        end
      end
      MEM_WAIT:   stall = (cnt_q != CW'(1));
`ifdef CTRL_MULDIV_EN
      MD_WAIT:    stall = (cnt_q != CW'(1));
`endif
      ECALL_WAIT: begin ecall = 1'b1; stall = !EcallDone_i; end
      FLUSH:      flush = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  assign commit     = !stall && !flush;
  assign MemRead_o  = rst_ni & cur.mem_read & !flush;
  assign MemtoReg_o = rst_ni & cur.mem_to_reg;
  assign MemWrite_o = rst_ni & cur.mem_write & commit;
  assign RegWrite_o = rst_ni & cur.reg_write & commit;
  assign Ecall_o    = rst_ni & ecall;
  assign ALUSrc_o   = rst_ni ? cur.alu_src : 2'b00;
  assign ALUOp_o    = rst_ni ? cur.alu_op : '0;
  assign Stall_o    = rst_ni & stall;
  assign Flush_o    = rst_ni & flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      dec_q   <= '0;
    end else if (doBranch_i) begin
      if (FLUSH_CYCLES > 0) begin
        state_q <= FLUSH;
        cnt_q   <= CW'(FLUSH_CYCLES);
      end else begin
        state_q <= RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          dec_q <= dec;
          if (is_ecall) begin
            if (!EcallDone_i) state_q <= ECALL_WAIT;
          end else if (is_mem && MEM_LAT > 0) begin
            state_q <= MEM_WAIT;
            cnt_q   <= CW'(MEM_LAT);
          end
`ifdef CTRL_MULDIV_EN
          else if (is_md && MULDIV_LAT > 0) begin
            state_q <= MD_WAIT;
            cnt_q   <= CW'(MULDIV_LAT);
          end
`endif
        end
        MEM_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RUN;
        end
`ifdef CTRL_MULDIV_EN
        MD_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RUN;
        end
`endif
        ECALL_WAIT: if (EcallDone_i) state_q <= RUN;
        FLUSH: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller (MEM_LAT=2, FLUSH_CYCLES=2, MULDIV_LAT=4).
// Observed vector: {MemRead,MemtoReg,MemWrite,RegWrite,Ecall,ALUSrc[1:0],ALUOp[3:0],Stall,Flush}.
module tb_pipelined_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        do_br, ec_done;
  logic        mem_read, mem_to_reg, mem_write, reg_write, ecall, stall, flush;
  logic [1:0]  alu_src;
  logic [3:0]  alu_op;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [31:0] LW = 32'h0000_2003, SW = 32'h0000_2023, ECALL = 32'h0000_0073;
  localparam logic [31:0] ADD = 32'h0000_0033, JAL = 32'h0000_006F, ADDI = 32'h0000_0013;
  localparam logic [31:0] MUL = 32'h0200_0033, BAD = 32'h0000_007F;

  localparam logic [12:0] Z      = 13'b00000_00_0000_00;
  localparam logic [12:0] LW_S   = 13'b11000_10_0010_10;
  localparam logic [12:0] LW_C   = 13'b11010_10_0010_00;
  localparam logic [12:0] SW_S   = 13'b00000_10_0010_10;
  localparam logic [12:0] SW_C   = 13'b00100_10_0010_00;
  localparam logic [12:0] ADD_C  = 13'b00010_00_0000_00;
  localparam logic [12:0] JAL_C  = 13'b00010_01_0100_00;
  localparam logic [12:0] EC_S   = 13'b00001_00_0000_10;
  localparam logic [12:0] EC_D   = 13'b00001_00_0000_00;
  localparam logic [12:0] ADDI_C = 13'b00010_10_0001_00;
  localparam logic [12:0] ADDI_F = 13'b00000_10_0001_01;
  localparam logic [12:0] MUL_S  = 13'b00000_00_0111_10;
  localparam logic [12:0] MUL_C  = 13'b00010_00_0111_00;

  always #5 clk = ~clk;

  pipelined_controller #(
    .MEM_LAT(2), .FLUSH_CYCLES(2), .MULDIV_LAT(4), .ALUOP_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .inst_i(inst), .doBranch_i(do_br), .EcallDone_i(ec_done),
    .MemRead_o(mem_read), .MemtoReg_o(mem_to_reg), .MemWrite_o(mem_write),
    .RegWrite_o(reg_write), .Ecall_o(ecall), .ALUSrc_o(alu_src), .ALUOp_o(alu_op),
    .Stall_o(stall), .Flush_o(flush)
  );

  function automatic logic [12:0] obs();
    return {mem_read, mem_to_reg, mem_write, reg_write, ecall, alu_src, alu_op, stall, flush};
  endfunction

  task automatic test_reset();
    logic [12:0] ev [3] = '{LW_S, LW_S, LW_C};
    rst_n = 1'b0; inst = LW; do_br = 1'b0; ec_done = 1'b0;
    #3;
    n_cmp++;
    if (obs() !== Z) begin n_bad++; $display("FAIL reset_initial got %b want %b", obs(), Z); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== LW_S) begin n_bad++; $display("FAIL reset_pre_lw cyc%0d got %b want %b", i, obs(), LW_S); end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== Z) begin n_bad++; $display("FAIL reset_async got %b want %b", obs(), Z); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL reset_fresh_lw cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  // Fetch changes to add while sw is stalled; the store must still commit as sw.
  task automatic test_store();
    logic [31:0] iv [4] = '{SW, ADD, ADD, ADD};
    logic [12:0] ev [4] = '{SW_S, SW_S, SW_C, ADD_C};
    for (int i = 0; i < 4; i++) begin
      inst = iv[i];
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL store cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ecall();
    logic [31:0] iv [6] = '{ECALL, ECALL, ECALL, ECALL, ECALL, ADDI};
    logic        dv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [12:0] ev [6] = '{EC_S, EC_S, EC_S, EC_S, EC_D, ADDI_C};
    for (int i = 0; i < 6; i++) begin
      inst = iv[i]; ec_done = dv[i];
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL ecall cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
    ec_done = 1'b0;
  endtask

  task automatic test_branch_ecall();
    logic [31:0] iv [5] = '{ECALL, ECALL, ADDI, ADDI, ADDI};
    logic        bv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [12:0] ev [5] = '{EC_S, EC_S, ADDI_F, ADDI_F, ADDI_C};
    for (int i = 0; i < 5; i++) begin
      inst = iv[i]; do_br = bv[i];
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL branch_ecall cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
    do_br = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] iv [4] = '{ADD, JAL, BAD, ADDI};
    logic [12:0] ev [4] = '{ADD_C, JAL_C, Z, ADDI_C};
    for (int i = 0; i < 4; i++) begin
      inst = iv[i];
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL alu cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  // Branch reload inside FLUSH, then a branch aborting MEM_WAIT.
  task automatic test_back_to_back();
    logic [31:0] iv [10] = '{JAL, ADDI, ADDI, ADDI, ADDI, LW, LW, ADDI, ADDI, ADDI};
    logic        bv [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [12:0] ev [10] = '{JAL_C, ADDI_F, ADDI_F, ADDI_F, ADDI_C,
                             LW_S, LW_S, ADDI_F, ADDI_F, ADDI_C};
    for (int i = 0; i < 10; i++) begin
      inst = iv[i]; do_br = bv[i];
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL back_to_back cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
    do_br = 1'b0;
  endtask

  task automatic test_muldiv();
`ifdef CTRL_MULDIV_EN
    logic [12:0] ev [6] = '{MUL_S, MUL_S, MUL_S, MUL_S, MUL_C, ADDI_C};
`else
    logic [12:0] ev [6] = '{ADD_C, ADD_C, ADD_C, ADD_C, ADD_C, ADDI_C};
`endif
    for (int i = 0; i < 6; i++) begin
      inst = (i == 5) ? ADDI : MUL;
      @(negedge clk);
      n_cmp++;
      if (obs() !== ev[i]) begin n_bad++; $display("FAIL muldiv cyc%0d got %b want %b", i, obs(), ev[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_ecall();
    test_branch_ecall();
    test_alu();
    test_back_to_back();
    test_muldiv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
